// File: rtl/bomb_pkg.sv
// Shared definitions for the bomb round judge: FSM state encoding, code width
// and default phase timings.
package bomb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHOW,
        ENTRY,
        WIN,
        LOSE,
        RESTART
    } state_t;

    localparam int unsigned CODE_W           = 5;
    localparam int unsigned SHOW_SEC_DEF     = 5;
    localparam int unsigned COUNT_SEC_DEF    = 20;
    localparam int unsigned END_HOLD_SEC_DEF = 3;
    localparam int unsigned MAX_TRIES_DEF    = 3;

endpackage

// File: rtl/sec_tick_gen.sv
// One-second prescaler: tick is high on the last cycle of each TICK_DIV period;
// clr restarts the period so the next cycle counts as cycle 0.
module sec_tick_gen #(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst_p,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt;

    always_comb begin
        tick = (cnt == CW'(TICK_DIV - 1));
    end

    always_ff @(posedge clk) begin
        if (rst_p || clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/bomb_round_judge.sv
// Round judge: times the code display and defuse countdown, checks confirmed
// switch codes against the latched secret, and reports win/lose then restart.
module bomb_round_judge #(
    parameter int unsigned TICK_DIV     = 50_000_000,
    parameter int unsigned SHOW_SEC     = bomb_pkg::SHOW_SEC_DEF,
    parameter int unsigned COUNT_SEC    = bomb_pkg::COUNT_SEC_DEF,
    parameter int unsigned MAX_TRIES    = bomb_pkg::MAX_TRIES_DEF,
    parameter int unsigned END_HOLD_SEC = bomb_pkg::END_HOLD_SEC_DEF,
    parameter int unsigned CODE_W       = bomb_pkg::CODE_W
) (
    input  logic              clk,
    input  logic              rst_p,
    input  logic              showing,
    input  logic              startInput,
    input  logic [CODE_W-1:0] random,
    input  logic [CODE_W-1:0] code_in,
    input  logic              confirm,
    output logic              endOfShow,
    output logic              infail,
    output logic              insuccess,
    output logic              repeatRst,
    output logic [CODE_W-1:0] secret,
    output logic [4:0]        sec_left,
    output logic [1:0]        tries_left
);

    import bomb_pkg::*;

    state_t     state;
    logic       confirm_d;
    logic       tick;
    logic       clr;
    logic       cfm_edge;
    logic       cfm_ok;
    logic       match;
    logic       last_sec;
    logic       out_of_tries;
    logic       abort;
    logic [4:0] sec_dec;
    logic [1:0] tries_dec;

    sec_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst_p(rst_p),
        .clr  (clr),
        .tick (tick)
    );

    // Event decode shared by the FSM and the prescaler clear, so the clear
    // fires on exactly the cycles where the state register changes.
    always_comb begin
        cfm_edge     = confirm & ~confirm_d;
        cfm_ok       = (state == ENTRY) && startInput && cfm_edge;
        match        = cfm_ok && (code_in == secret);
        last_sec     = tick && (sec_left == 5'd1);
        out_of_tries = cfm_ok && !match && (tries_left <= 2'd1);
        abort        = !showing && (state inside {SHOW, ENTRY, WIN, LOSE});
        sec_dec      = (sec_left == '0) ? '0 : sec_left - 5'd1;
        tries_dec    = (tries_left == '0) ? '0 : tries_left - 2'd1;

        clr = 1'b0;
        case (state)
            IDLE:      clr = showing;
            SHOW:      clr = abort || last_sec;
            ENTRY:     clr = abort || match || out_of_tries || last_sec;
            WIN, LOSE: clr = abort || last_sec;
            RESTART:   clr = 1'b1;
            default:   clr = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_p) begin
            state      <= IDLE;
            confirm_d  <= 1'b0;
            endOfShow  <= 1'b0;
            infail     <= 1'b0;
            insuccess  <= 1'b0;
            repeatRst  <= 1'b0;
            secret     <= '0;
            sec_left   <= '0;
            tries_left <= '0;
        end else begin
            confirm_d <= confirm;
            repeatRst <= 1'b0;
            if (abort) begin
                state      <= IDLE;
                endOfShow  <= 1'b0;
                infail     <= 1'b0;
                insuccess  <= 1'b0;
                secret     <= '0;
                sec_left   <= '0;
                tries_left <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (showing) begin
                            secret     <= random;
                            sec_left   <= 5'(SHOW_SEC);
                            tries_left <= 2'(MAX_TRIES);
                            state      <= SHOW;
                        end
                    end
                    SHOW: begin
                        if (last_sec) begin
                            endOfShow <= 1'b1;
                            sec_left  <= 5'(COUNT_SEC);
                            state     <= ENTRY;
                        end else if (tick) begin
                            sec_left <= sec_dec;
                        end
                    end
                    ENTRY: begin
                        if (match) begin
                            insuccess <= 1'b1;
                            sec_left  <= 5'(END_HOLD_SEC);
                            state     <= WIN;
                        end else begin
                            if (cfm_ok) begin
                                tries_left <= tries_dec;
                            end
                            if (out_of_tries || last_sec) begin
                                infail   <= 1'b1;
                                sec_left <= 5'(END_HOLD_SEC);
                                state    <= LOSE;
                            end else if (tick) begin
                                sec_left <= sec_dec;
                            end
                        end
                    end
                    WIN, LOSE: begin
                        if (last_sec) begin
                            sec_left  <= '0;
                            repeatRst <= 1'b1;
                            infail    <= 1'b0;
                            insuccess <= 1'b0;
                            endOfShow <= 1'b0;
                            state     <= RESTART;
                        end else if (tick) begin
                            sec_left <= sec_dec;
                        end
                    end
                    RESTART: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
